// File: rtl/stack_sequencer.sv
// stack_sequencer: initiator-side controller for a single-port operand stack.
// Each compound stack operation (PUSH, POP, DUP, SWAP, POP2, ADD) is split into
// single push/pop transactions. One transaction is outstanding at a time.
// Illegal operations are refused before any stack traffic is issued.
module stack_sequencer #(
    parameter int STACKDATA = 32,
    parameter int STACKSIZE = 65_536,
    parameter int DEPTHW    = 17
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2:0]           op,
    input  logic [STACKDATA-1:0] operand,
    output logic                 busy,
    output logic                 op_done,
    output logic                 error,
    output logic [STACKDATA-1:0] result_a,
    output logic [STACKDATA-1:0] result_b,
    output logic [DEPTHW-1:0]    depth,
    output logic                 stk_push,
    output logic                 stk_trigger,
    output logic [STACKDATA-1:0] stk_writevalue,
    input  logic [STACKDATA-1:0] stk_readvalue,
    input  logic                 stk_done
);

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_PUSH = 3'd1;
    localparam logic [2:0] OP_POP  = 3'd2;
    localparam logic [2:0] OP_DUP  = 3'd3;
    localparam logic [2:0] OP_SWAP = 3'd4;
    localparam logic [2:0] OP_POP2 = 3'd5;
    localparam logic [2:0] OP_ADD  = 3'd6;
    localparam logic [2:0] OP_RSVD = 3'd7;

    // Source of the word written by a push micro-op.
    localparam logic [1:0] SRC_OPERAND = 2'd0;
    localparam logic [1:0] SRC_A       = 2'd1;
    localparam logic [1:0] SRC_B       = 2'd2;
    localparam logic [1:0] SRC_SUM     = 2'd3;

    // Depth comparisons are done one bit wider so depth+1 cannot wrap.
    localparam logic [DEPTHW:0]   SIZE_EXT  = (DEPTHW + 1)'(STACKSIZE);
    localparam logic [DEPTHW:0]   EXT_ONE   = (DEPTHW + 1)'(1);
    localparam logic [DEPTHW-1:0] DEPTH_ONE = DEPTHW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ISSUE,
        S_WAIT,
        S_FINISH
    } state_t;

    state_t               state_reg;
    state_t               state_next;
    logic [2:0]           op_reg;
    logic [STACKDATA-1:0] operand_reg;
    logic [STACKDATA-1:0] a_reg;
    logic [STACKDATA-1:0] b_reg;
    logic [STACKDATA-1:0] result_a_reg;
    logic [STACKDATA-1:0] result_b_reg;
    logic [DEPTHW-1:0]    depth_reg;
    logic [1:0]           step_reg;
    logic                 err_reg;

    // Current micro-op, decoded from (op_reg, step_reg).
    logic                 m_push;
    logic                 m_dst_b;
    logic                 m_last;
    logic [1:0]           m_src;
    logic [STACKDATA-1:0] push_data;

    // Legality of the latched operation against the current depth.
    logic [1:0]           need_pops;
    logic                 grows;
    logic                 illegal;

    // Legality: enough words to pop, room to grow, opcode not reserved.
    always_comb begin
        need_pops = 2'd0;
        grows     = 1'b0;
        illegal   = 1'b0;
        case (op_reg)
            OP_PUSH: grows = 1'b1;
            OP_POP:  need_pops = 2'd1;
            OP_DUP: begin
                need_pops = 2'd1;
                grows     = 1'b1;
            end
            OP_SWAP, OP_POP2, OP_ADD: need_pops = 2'd2;
            OP_RSVD: illegal = 1'b1;
            default: ;
        endcase
        if (depth_reg < DEPTHW'(need_pops)) begin
            illegal = 1'b1;
        end
        if (grows && (({1'b0, depth_reg} + EXT_ONE) > SIZE_EXT)) begin
            illegal = 1'b1;
        end
    end

    // Micro-op list per operation; pops always come before pushes.
    always_comb begin
        m_push  = 1'b0;
        m_dst_b = 1'b0;
        m_last  = 1'b1;
        m_src   = SRC_OPERAND;
        case (op_reg)
            OP_PUSH: begin
                m_push = 1'b1;
                m_src  = SRC_OPERAND;
            end
            OP_DUP: begin
                case (step_reg)
                    2'd0: m_last = 1'b0;
                    2'd1: begin
                        m_push = 1'b1;
                        m_src  = SRC_A;
                        m_last = 1'b0;
                    end
                    default: begin
                        m_push = 1'b1;
                        m_src  = SRC_A;
                    end
                endcase
            end
            OP_SWAP: begin
                case (step_reg)
                    2'd0: m_last = 1'b0;
                    2'd1: begin
                        m_dst_b = 1'b1;
                        m_last  = 1'b0;
                    end
                    2'd2: begin
                        m_push = 1'b1;
                        m_src  = SRC_A;
                        m_last = 1'b0;
                    end
                    default: begin
                        m_push = 1'b1;
                        m_src  = SRC_B;
                    end
                endcase
            end
            OP_POP2: begin
                if (step_reg == 2'd0) begin
                    m_last = 1'b0;
                end else begin
                    m_dst_b = 1'b1;
                end
            end
            OP_ADD: begin
                case (step_reg)
                    2'd0: m_last = 1'b0;
                    2'd1: begin
                        m_dst_b = 1'b1;
                        m_last  = 1'b0;
                    end
                    default: begin
                        m_push = 1'b1;
                        m_src  = SRC_SUM;
                    end
                endcase
            end
            default: ;
        endcase
    end

    // Push data select; the ADD carry is simply dropped.
    always_comb begin
        case (m_src)
            SRC_A:   push_data = a_reg;
            SRC_B:   push_data = b_reg;
            SRC_SUM: push_data = a_reg + b_reg;
            default: push_data = operand_reg;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                if (illegal || (op_reg == OP_NOP)) begin
                    state_next = S_FINISH;
                end else begin
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: state_next = S_WAIT;
            S_WAIT: begin
                if (stk_done) begin
                    state_next = m_last ? S_FINISH : S_ISSUE;
                end
            end
            S_FINISH: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Datapath: request latch, pop capture, depth tracking, result update.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_reg       <= OP_NOP;
            operand_reg  <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            result_a_reg <= '0;
            result_b_reg <= '0;
            depth_reg    <= '0;
            step_reg     <= 2'd0;
            err_reg      <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        op_reg      <= op;
                        operand_reg <= operand;
                        step_reg    <= 2'd0;
                    end
                end
                S_CHECK: err_reg <= illegal;
                S_WAIT: begin
                    if (stk_done) begin
                        step_reg <= step_reg + 2'd1;
                        if (m_push) begin
                            depth_reg <= depth_reg + DEPTH_ONE;
                        end else begin
                            depth_reg <= depth_reg - DEPTH_ONE;
                            if (m_dst_b) begin
                                b_reg <= stk_readvalue;
                            end else begin
                                a_reg <= stk_readvalue;
                            end
                        end
                        // Results must be valid during the op_done cycle, so
                        // they load on the edge that enters FINISH, including
                        // a word popped on that same edge.
                        if (m_last) begin
                            result_a_reg <= (!m_push && !m_dst_b) ? stk_readvalue : a_reg;
                            result_b_reg <= (!m_push && m_dst_b) ? stk_readvalue : b_reg;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from the current state.
    always_comb begin
        busy           = (state_reg == S_CHECK) || (state_reg == S_ISSUE) ||
                         (state_reg == S_WAIT);
        op_done        = (state_reg == S_FINISH);
        error          = (state_reg == S_FINISH) && err_reg;
        stk_trigger    = (state_reg == S_ISSUE);
        stk_push       = (state_reg == S_ISSUE) && m_push;
        stk_writevalue = ((state_reg == S_ISSUE) && m_push) ? push_data : '0;
        result_a       = result_a_reg;
        result_b       = result_b_reg;
        depth          = depth_reg;
    end

endmodule

// File: doc/stack_sequencer.md
Name: stack_sequencer

Overview:
- Initiator-side controller for the single-port operand stack (push/trigger/done handshake).
- Accepts one compound stack operation per request from the execute stage: PUSH, POP, DUP, SWAP, POP2 or ADD.
- Breaks each operation into single push/pop transactions and issues them to the stack one at a time.
- Tracks stack depth so that underflow and overflow are refused before any stack traffic is issued.

Parameters:
- STACKDATA, 32, word width; must match the stack instance.
- STACKSIZE, 65_536, stack capacity in words; must match the stack instance.
- DEPTHW, 17, depth counter width; must satisfy 2^DEPTHW > STACKSIZE.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  operation request; sampled only while busy=0
- op  in  3  opcode: 0 NOP, 1 PUSH, 2 POP, 3 DUP, 4 SWAP, 5 POP2, 6 ADD, 7 reserved
- operand  in  STACKDATA  value for PUSH; captured with start
- busy  out  1  operation in progress
- op_done  out  1  one-cycle pulse when an operation completes or is refused
- error  out  1  valid with op_done: 1 = refused (underflow, overflow or reserved op)
- result_a  out  STACKDATA  first word popped (old top of stack)
- result_b  out  STACKDATA  second word popped
- depth  out  DEPTHW  current number of words on the stack
- stk_push  out  1  to stack: 1 = push, 0 = pop
- stk_trigger  out  1  to stack: one-cycle transaction strobe
- stk_writevalue  out  STACKDATA  to stack: push data
- stk_readvalue  in  STACKDATA  from stack: pop data, valid while stk_done=1
- stk_done  in  1  from stack: one-cycle transaction complete

Behaviour:
- Reset values: busy, op_done, error, stk_trigger and stk_push are 0; result_a, result_b, stk_writevalue and depth are 0; state is IDLE. The stack shares rst, so the stack and the sequencer empty together.
- A reset mid-operation abandons the sequence and returns to IDLE with no further trigger.
- States: IDLE, CHECK, ISSUE, WAIT, FINISH.
- IDLE -> CHECK when start=1: latch op and operand; busy=1 from the next cycle.
- CHECK (1 cycle): evaluate the legality rules below.
  - Illegal -> FINISH with error=1 and no stack traffic.
  - NOP -> FINISH with error=0.
  - Otherwise load the micro-op list -> ISSUE.
- Micro-op lists (pops listed first):
  - PUSH: push operand.
  - POP: pop -> a.
  - DUP: pop -> a; push a; push a.
  - SWAP: pop -> a; pop -> b; push a; push b.
  - POP2: pop -> a; pop -> b.
  - ADD: pop -> a; pop -> b; push (a+b) mod 2^STACKDATA (carry discarded).
- Legality: the op needs k pops and a net growth g.
  - Underflow when depth < k: POP k=1, DUP k=1, SWAP/POP2/ADD k=2.
  - Overflow when depth + g > STACKSIZE: PUSH g=+1, DUP g=+1.
  - Op 7 is always illegal.
- ISSUE (1 cycle): stk_trigger=1 and stk_push set per micro-op; stk_writevalue valid in the same cycle -> WAIT.
- WAIT: hold stk_trigger=0 until stk_done=1.
  - On a pop, capture stk_readvalue into a or b in that cycle.
  - Depth is updated +1 or -1 in that cycle.
  - Then go to ISSUE for the next micro-op, or to FINISH after the last one.
- Exactly one transaction is outstanding at a time; the trigger is never reasserted before done is seen.
- stk_done arriving outside WAIT is ignored.
- FINISH (1 cycle): op_done=1; error as decided; result_a=a and result_b=b (unchanged for ops that do not pop) -> IDLE.
  - busy drops in the same cycle as the op_done pulse, so a new start may be presented in the cycle after op_done.
- With the standard stack (done 2 cycles after trigger), latency from the start-sampled cycle to op_done:
  - PUSH/POP: 5 cycles.
  - POP2/ADD(2 pops)+push: 3 cycles per transaction plus 2.
  - Refused op: 2 cycles.
- depth never exceeds STACKSIZE and never wraps below 0.

Test Plan:
- PUSH 0x11, PUSH 0x22, POP2 -> result_a=0x22, result_b=0x11, depth=0, error=0, op_done 5 cycles after each PUSH start.
- POP on empty after reset -> op_done with error=1 two cycles after start; stk_trigger never asserted; depth stays 0.
- PUSH 0xFFFF_FFFF, PUSH 0x2, ADD, POP -> result_a=0x0000_0001, depth=0.
- PUSH 5, PUSH 7, SWAP, POP -> result_a=5; then POP -> result_a=7. PUSH 9, DUP, POP2 -> result_a=result_b=9.
- Reduced STACKSIZE=4: four PUSHes succeed; 5th PUSH and DUP are refused with error=1; depth=4.
- Assert rst during the WAIT of a SWAP -> busy=0, depth=0, no trigger after reset; a following PUSH 3 then POP returns 3. Also: start held high while busy is ignored (only one op_done per accepted start).
